// File: rtl/board_io_adapter.sv
// board_io_adapter: board-level I/O front end.
// Debounces raw key pins, drives LEDs with per-LED PWM brightness and
// reduces the internal pixel colour depth to the board's depth with optional
// 4x4 ordered dithering. Single clock domain, synchronous active-high reset,
// every output registered.
module board_io_adapter #(
    parameter int unsigned KEYS_W          = 3,
    parameter int unsigned LEDS_W          = 2,
    parameter bit          KEY_ACTIVE_LOW  = 1'b1,
    parameter bit          LED_ACTIVE_LOW  = 1'b0,
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned PWM_W           = 8,
    parameter int unsigned COLOR_W         = 8,
    parameter int unsigned OUT_COLOR_W     = 8,
    parameter bit          DITHER_EN       = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [KEYS_W-1:0]          keys_raw_i,
    output logic [KEYS_W-1:0]          key_o,
    output logic [KEYS_W-1:0]          key_press_o,
    output logic [KEYS_W-1:0]          key_release_o,
    input  logic [LEDS_W*PWM_W-1:0]    led_duty_i,
    output logic [LEDS_W-1:0]          led_o,
    input  logic [3*COLOR_W-1:0]       pixel_rgb_i,
    input  logic                       pixel_valid_i,
    input  logic [1:0]                 pixel_x_i,
    input  logic [1:0]                 pixel_y_i,
    output logic [3*OUT_COLOR_W-1:0]   rgb_o,
    output logic                       rgb_valid_o
);

    // ------------------------------------------------------------------
    // Parameter sanity
    // ------------------------------------------------------------------
    if (OUT_COLOR_W > COLOR_W || OUT_COLOR_W < 1 || DEBOUNCE_CYCLES < 2) begin : g_bad_params
        $error("board_io_adapter: need 1 <= OUT_COLOR_W <= COLOR_W and DEBOUNCE_CYCLES >= 2");
    end

    localparam int unsigned       CNT_W        = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [KEYS_W-1:0] KEY_RELEASED = {KEYS_W{KEY_ACTIVE_LOW}};
    localparam logic [LEDS_W-1:0] LED_IDLE     = {LEDS_W{LED_ACTIVE_LOW}};
    localparam int unsigned       DROP         = COLOR_W - OUT_COLOR_W;

    // 4x4 Bayer threshold matrix, row-major, indexed by {y[1:0], x[1:0]}
    localparam logic [3:0] BAYER [16] = '{
        4'd0,  4'd8,  4'd2,  4'd10,
        4'd12, 4'd4,  4'd14, 4'd6,
        4'd3,  4'd11, 4'd1,  4'd9,
        4'd15, 4'd7,  4'd13, 4'd5
    };

    // ------------------------------------------------------------------
    // Key path
    // ------------------------------------------------------------------
    logic [KEYS_W-1:0] sync1_q, sync2_q;
    logic [KEYS_W-1:0] key_q, key_d;
    logic [KEYS_W-1:0] press_q, press_d;
    logic [KEYS_W-1:0] release_q, release_d;
    logic [CNT_W-1:0]  cnt_q [KEYS_W];
    logic [CNT_W-1:0]  cnt_d [KEYS_W];
    logic [KEYS_W-1:0] key_s;

    // Debounce: count consecutive samples disagreeing with key_q, flip after DEBOUNCE_CYCLES
    always_comb begin
        key_s     = sync2_q ^ KEY_RELEASED;
        key_d     = key_q;
        press_d   = '0;
        release_d = '0;
        for (int unsigned k = 0; k < KEYS_W; k++) begin
            cnt_d[k] = '0;
            if (key_s[k] != key_q[k]) begin
                if (cnt_q[k] == CNT_LAST) begin
                    key_d[k]     = key_s[k];
                    press_d[k]   = key_s[k];
                    release_d[k] = ~key_s[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + 1'b1;
                end
            end
        end
    end

    // Synchroniser, debounce counters and debounced key state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q   <= KEY_RELEASED;
            sync2_q   <= KEY_RELEASED;
            key_q     <= '0;
            press_q   <= '0;
            release_q <= '0;
            cnt_q     <= '{default: '0};
        end else begin
            sync1_q   <= keys_raw_i;
            sync2_q   <= sync1_q;
            key_q     <= key_d;
            press_q   <= press_d;
            release_q <= release_d;
            cnt_q     <= cnt_d;
        end
    end

    assign key_o         = key_q;
    assign key_press_o   = press_q;
    assign key_release_o = release_q;

    // ------------------------------------------------------------------
    // LED PWM path
    // ------------------------------------------------------------------
    logic [PWM_W-1:0]  pwm_q, pwm_d;
    logic [LEDS_W-1:0] led_q, led_d;

    // Compare the free-running counter against each duty, then apply pin polarity
    always_comb begin
        pwm_d = pwm_q + 1'b1;
        led_d = LED_IDLE;
        for (int unsigned j = 0; j < LEDS_W; j++) begin
            led_d[j] = (pwm_q < led_duty_i[j*PWM_W +: PWM_W]) ^ LED_ACTIVE_LOW;
        end
    end

    // PWM counter and LED pin registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pwm_q <= '0;
            led_q <= LED_IDLE;
        end else begin
            pwm_q <= pwm_d;
            led_q <= led_d;
        end
    end

    assign led_o = led_q;

    // ------------------------------------------------------------------
    // Colour path
    // ------------------------------------------------------------------
    logic [3:0]                bayer_t;
    logic [COLOR_W:0]          t_raw;
    logic [COLOR_W:0]          t_scaled;
    logic [COLOR_W:0]          sum_w [3];
    logic [COLOR_W-1:0]        sat_w [3];
    logic [3*OUT_COLOR_W-1:0]  rgb_q, rgb_d;
    logic                      rgb_valid_q;

    assign bayer_t = BAYER[{pixel_y_i, pixel_x_i}];

    // Pass-through needs no separate branch: with DROP == 0 the threshold
    // shifts down to zero and the add/saturate/truncate chain is the identity.
    if (DROP >= 4) begin : g_scale_up
        assign t_raw = (COLOR_W + 1)'(bayer_t) << (DROP - 4);
    end else begin : g_scale_down
        logic [3:0] t_dn;
        assign t_dn  = bayer_t >> (4 - DROP);
        assign t_raw = (COLOR_W + 1)'(t_dn);
    end

    assign t_scaled = DITHER_EN ? t_raw : '0;

    // Per channel: add threshold, saturate, keep the top OUT_COLOR_W bits; blank outside active video
    always_comb begin
        rgb_d = '0;
        for (int unsigned ch = 0; ch < 3; ch++) begin
            sum_w[ch] = {1'b0, pixel_rgb_i[ch*COLOR_W +: COLOR_W]} + t_scaled;
            sat_w[ch] = sum_w[ch][COLOR_W] ? '1 : sum_w[ch][COLOR_W-1:0];
            rgb_d[ch*OUT_COLOR_W +: OUT_COLOR_W] = sat_w[ch][COLOR_W-1 -: OUT_COLOR_W];
        end
        if (!pixel_valid_i) begin
            rgb_d = '0;
        end
    end

    // Output colour and valid registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rgb_q       <= '0;
            rgb_valid_q <= 1'b0;
        end else begin
            rgb_q       <= rgb_d;
            rgb_valid_q <= pixel_valid_i;
        end
    end

    assign rgb_o       = rgb_q;
    assign rgb_valid_o = rgb_valid_q;

endmodule

// File: tb/tb_board_io_adapter.sv
// tb_board_io_adapter: three adapter configurations driven from shared pins
// and compared every cycle against a behavioural reference model.
//   a: active-low keys, active-high LEDs, 1-bit colour with dithering
//   b: active-high keys, active-low LEDs, 8-bit pass-through colour
//   c: active-low keys, active-high LEDs, 6-bit colour with dithering
module tb_board_io_adapter;

    localparam int unsigned KW = 3;
    localparam int unsigned LW = 3;
    localparam int unsigned PW = 8;
    localparam int unsigned CW = 8;
    localparam int unsigned DC = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [KW-1:0]     keys_raw;
    logic [LW*PW-1:0]  led_duty;
    logic [3*CW-1:0]   pixel_rgb;
    logic              pixel_valid;
    logic [1:0]        px, py;

    logic [KW-1:0] key_a, prs_a, rel_a, key_b, prs_b, rel_b, key_c, prs_c, rel_c;
    logic [LW-1:0] led_a, led_b, led_c;
    logic [2:0]    rgb_a;
    logic [23:0]   rgb_b;
    logic [17:0]   rgb_c;
    logic          vld_a, vld_b, vld_c;

    always #5 clk = ~clk;

    board_io_adapter #(.KEYS_W(KW), .LEDS_W(LW), .KEY_ACTIVE_LOW(1'b1), .LED_ACTIVE_LOW(1'b0),
        .DEBOUNCE_CYCLES(DC), .PWM_W(PW), .COLOR_W(CW), .OUT_COLOR_W(1), .DITHER_EN(1'b1)) u_a (
        .clk_i(clk), .rst_i(rst), .keys_raw_i(keys_raw), .key_o(key_a), .key_press_o(prs_a),
        .key_release_o(rel_a), .led_duty_i(led_duty), .led_o(led_a), .pixel_rgb_i(pixel_rgb),
        .pixel_valid_i(pixel_valid), .pixel_x_i(px), .pixel_y_i(py), .rgb_o(rgb_a), .rgb_valid_o(vld_a));

    board_io_adapter #(.KEYS_W(KW), .LEDS_W(LW), .KEY_ACTIVE_LOW(1'b0), .LED_ACTIVE_LOW(1'b1),
        .DEBOUNCE_CYCLES(DC), .PWM_W(PW), .COLOR_W(CW), .OUT_COLOR_W(8), .DITHER_EN(1'b1)) u_b (
        .clk_i(clk), .rst_i(rst), .keys_raw_i(keys_raw), .key_o(key_b), .key_press_o(prs_b),
        .key_release_o(rel_b), .led_duty_i(led_duty), .led_o(led_b), .pixel_rgb_i(pixel_rgb),
        .pixel_valid_i(pixel_valid), .pixel_x_i(px), .pixel_y_i(py), .rgb_o(rgb_b), .rgb_valid_o(vld_b));

    board_io_adapter #(.KEYS_W(KW), .LEDS_W(LW), .KEY_ACTIVE_LOW(1'b1), .LED_ACTIVE_LOW(1'b0),
        .DEBOUNCE_CYCLES(DC), .PWM_W(PW), .COLOR_W(CW), .OUT_COLOR_W(6), .DITHER_EN(1'b1)) u_c (
        .clk_i(clk), .rst_i(rst), .keys_raw_i(keys_raw), .key_o(key_c), .key_press_o(prs_c),
        .key_release_o(rel_c), .led_duty_i(led_duty), .led_o(led_c), .pixel_rgb_i(pixel_rgb),
        .pixel_valid_i(pixel_valid), .pixel_x_i(px), .pixel_y_i(py), .rgb_o(rgb_c), .rgb_valid_o(vld_c));

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    int bayer [4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};

    logic [KW-1:0] m_s1 [3], m_s2 [3], m_key [3], m_prs [3], m_rel [3];
    logic [DC-1:0] m_win [3][KW];
    int            m_fill [3][KW];
    logic [LW-1:0] m_led [3];
    logic [31:0]   m_rgb [3];
    logic          m_vld [3];
    int            m_since = 0;

    function automatic bit kal(input int i);
        return (i != 1);
    endfunction

    function automatic bit lal(input int i);
        return (i == 1);
    endfunction

    function automatic int outw(input int i);
        return (i == 0) ? 1 : (i == 1) ? 8 : 6;
    endfunction

    function automatic logic [31:0] colour_ref(input logic [23:0] pv, input int x, input int y, input int ow);
        int d;
        int t;
        int c;
        int s;
        logic [31:0] res;
        d = CW - ow;
        t = bayer[y][x];
        if (d >= 4) t = t * (1 << (d - 4));
        else        t = t / (1 << (4 - d));
        res = 0;
        for (int ch = 2; ch >= 0; ch--) begin
            c = int'((pv >> (ch * 8)) & 24'hFF);
            s = c + t;
            if (s > 255) s = 255;
            res = (res << ow) | 32'(s / (1 << d));
        end
        return res;
    endfunction

    // Advance the model by one clock edge using the inputs currently applied
    task automatic model_edge();
        logic s;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_s1[i]  = {KW{kal(i)}};
                m_s2[i]  = {KW{kal(i)}};
                m_key[i] = '0;
                m_prs[i] = '0;
                m_rel[i] = '0;
                for (int k = 0; k < KW; k++) begin
                    m_win[i][k]  = '0;
                    m_fill[i][k] = 0;
                end
                m_led[i] = {LW{lal(i)}};
                m_rgb[i] = 0;
                m_vld[i] = 1'b0;
            end else begin
                m_prs[i] = '0;
                m_rel[i] = '0;
                for (int k = 0; k < KW; k++) begin
                    // key flips once the last DC synchronised samples all disagree with it
                    s = m_s2[i][k] ^ kal(i);
                    m_win[i][k] = {m_win[i][k][DC-2:0], s};
                    if (m_fill[i][k] < DC) m_fill[i][k]++;
                    if (m_fill[i][k] == DC && m_win[i][k] == (m_key[i][k] ? {DC{1'b0}} : {DC{1'b1}})) begin
                        m_key[i][k] = ~m_key[i][k];
                        if (m_key[i][k]) m_prs[i][k] = 1'b1;
                        else             m_rel[i][k] = 1'b1;
                    end
                end
                m_s2[i] = m_s1[i];
                m_s1[i] = keys_raw;
                for (int j = 0; j < LW; j++) begin
                    m_led[i][j] = ((m_since % 256) < int'(led_duty[j*PW +: PW])) ^ lal(i);
                end
                m_rgb[i] = pixel_valid ? colour_ref(pixel_rgb, int'(px), int'(py), outw(i)) : 32'd0;
                m_vld[i] = pixel_valid;
            end
        end
        m_since = rst ? 0 : m_since + 1;
    endtask

    task automatic compare_all();
        check("a.key", 32'(key_a), 32'(m_key[0]));
        check("a.press", 32'(prs_a), 32'(m_prs[0]));
        check("a.release", 32'(rel_a), 32'(m_rel[0]));
        check("a.led", 32'(led_a), 32'(m_led[0]));
        check("a.rgb", 32'(rgb_a), m_rgb[0]);
        check("a.valid", 32'(vld_a), 32'(m_vld[0]));
        check("b.key", 32'(key_b), 32'(m_key[1]));
        check("b.press", 32'(prs_b), 32'(m_prs[1]));
        check("b.release", 32'(rel_b), 32'(m_rel[1]));
        check("b.led", 32'(led_b), 32'(m_led[1]));
        check("b.rgb", 32'(rgb_b), m_rgb[1]);
        check("b.valid", 32'(vld_b), 32'(m_vld[1]));
        check("c.key", 32'(key_c), 32'(m_key[2]));
        check("c.press", 32'(prs_c), 32'(m_prs[2]));
        check("c.release", 32'(rel_c), 32'(m_rel[2]));
        check("c.led", 32'(led_c), 32'(m_led[2]));
        check("c.rgb", 32'(rgb_c), m_rgb[2]);
        check("c.valid", 32'(vld_c), 32'(m_vld[2]));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // Step until instance a reports a press (sel 0) or release (sel 1) on key 0, bounded
    task automatic steps_until_a(input int sel, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!((sel == 0) ? prs_a[0] : rel_a[0]) && n < 40);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int n;
        int presses;
        int lit_a [LW];
        int lit_b [LW];

        rst         = 1'b1;
        keys_raw    = '1;
        led_duty    = '0;
        pixel_rgb   = '0;
        pixel_valid = 1'b0;
        px          = '0;
        py          = '0;

        repeat (4) step();
        check("rst.key_a", 32'(key_a), 32'd0);
        check("rst.led_a", 32'(led_a), 32'd0);
        check("rst.led_b", 32'(led_b), 32'h7);
        check("rst.rgb_a", 32'(rgb_a), 32'd0);
        check("rst.valid_b", 32'(vld_b), 32'd0);

        rst = 1'b0;
        repeat (20) step();

        // Clean press and release on key 0
        keys_raw[0] = 1'b0;
        steps_until_a(0, n);
        check("deb.press_latency", n, 10);
        check("deb.key_high", 32'(key_a[0]), 32'd1);
        step();
        check("deb.press_one_cycle", 32'(prs_a[0]), 32'd0);
        repeat (5) step();
        keys_raw[0] = 1'b1;
        steps_until_a(1, n);
        check("deb.release_latency", n, 10);
        repeat (5) step();

        // Lone 5-cycle glitch
        presses = 0;
        keys_raw[0] = 1'b0;
        repeat (5) begin step(); presses += int'(prs_a[0]); end
        keys_raw[0] = 1'b1;
        repeat (20) begin step(); presses += int'(prs_a[0]); end
        check("glitch.no_press", presses, 0);

        // Bounce: low 5, high 2, low 20
        presses = 0;
        keys_raw[0] = 1'b0;
        repeat (5) begin step(); presses += int'(prs_a[0]); end
        keys_raw[0] = 1'b1;
        repeat (2) begin step(); presses += int'(prs_a[0]); end
        check("bounce.no_early_press", presses, 0);
        keys_raw[0] = 1'b0;
        steps_until_a(0, n);
        check("bounce.latency", n, 10);
        repeat (10) step();

        // Key held through reset
        rst = 1'b1;
        repeat (3) step();
        check("rsthold.key_cleared", 32'(key_a[0]), 32'd0);
        rst = 1'b0;
        steps_until_a(0, n);
        check("rsthold.press_latency", n, 10);
        keys_raw = '1;
        repeat (12) step();

        // PWM lit counts over two full periods
        led_duty = {8'd255, 8'd64, 8'd0};
        for (int j = 0; j < LW; j++) begin lit_a[j] = 0; lit_b[j] = 0; end
        repeat (512) begin
            step();
            for (int j = 0; j < LW; j++) begin
                lit_a[j] += int'(led_a[j]);
                lit_b[j] += int'(!led_b[j]);
            end
        end
        check("pwm.a_duty0", lit_a[0], 0);
        check("pwm.a_duty64", lit_a[1], 128);
        check("pwm.a_duty255", lit_a[2], 510);
        check("pwm.b_duty0", lit_b[0], 0);
        check("pwm.b_duty64", lit_b[1], 128);
        check("pwm.b_duty255", lit_b[2], 510);

        // Colour depth reduction on instance a, pass-through on b
        pixel_valid = 1'b1;
        pixel_rgb = 24'h800000; px = 2'd0; py = 2'd0; step();
        check("col.r80_t0", 32'(rgb_a), 32'h4);
        pixel_rgb = 24'h700000; px = 2'd0; py = 2'd0; step();
        check("col.r70_t0", 32'(rgb_a), 32'h0);
        pixel_rgb = 24'h700000; px = 2'd1; py = 2'd1; step();
        check("col.r70_t32", 32'(rgb_a), 32'h4);
        pixel_rgb = 24'hFF0000; px = 2'd3; py = 2'd1; step();
        check("col.rff_sat", 32'(rgb_a), 32'h4);
        pixel_rgb = 24'h12AB34;
        for (int y = 0; y < 4; y += 3) begin
            for (int x = 0; x < 4; x++) begin
                px = 2'(x); py = 2'(y); step();
                check("col.passthrough", 32'(rgb_b), 32'h12AB34);
            end
        end
        pixel_valid = 1'b0; step();
        check("col.blank_rgb_a", 32'(rgb_a), 32'd0);
        check("col.blank_valid_a", 32'(vld_a), 32'd0);
        check("col.blank_rgb_b", 32'(rgb_b), 32'd0);

        // Randomised traffic on all paths, with occasional resets
        repeat (2000) begin
            for (int k = 0; k < KW; k++) begin
                if ($urandom_range(11) == 0) keys_raw[k] = ~keys_raw[k];
            end
            if ($urandom_range(63) == 0) led_duty = 24'($urandom);
            case ($urandom_range(7))
                0:       pixel_rgb = 24'hFFFFFF;
                1:       pixel_rgb = 24'hF8FCF0;
                default: pixel_rgb = 24'($urandom);
            endcase
            px          = 2'($urandom);
            py          = 2'($urandom);
            pixel_valid = ($urandom_range(3) != 0);
            rst         = ($urandom_range(499) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
